// File: rtl/float_to_fix.sv
// IEEE-754 single precision to signed Q(OUT_W-FRAC).FRAC converter.
// Round-half-away-from-zero, saturating, NaN flagged; result 3 edges after acceptance.
module float_to_fix #(
   parameter int OUT_W = 24,
   parameter int FRAC  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data,
   output logic             ovf,
   output logic             nan
);

   // One spare bit above OUT_W so the most-negative magnitude survives to the sign stage.
   localparam int MAG_W = OUT_W + 1;
   localparam logic signed [10:0] BIAS_S    = 11'sd150 - $signed(11'(FRAC));
   localparam logic signed [10:0] OVF_SHIFT = $signed(11'(OUT_W - 23));
   localparam logic [MAG_W-1:0]   POS_MAX   = {2'b00, {(OUT_W-1){1'b1}}};
   localparam logic [MAG_W-1:0]   NEG_MAG   = {2'b01, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0]   SAT_POS   = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0]   SAT_NEG   = {1'b1, {(OUT_W-1){1'b0}}};

   logic             s1_valid_r, s1_sign_r, s1_zero_r, s1_inf_r, s1_nan_r;
   logic [7:0]       s1_exp_r;
   logic [23:0]      s1_mant_r;

   logic signed [10:0] shift_s, neg_s;
   logic [MAG_W-1:0]   lmag_s, mag_s;
   logic [24:0]        rv_s;
   logic               guard_s, ovf_s;

   logic             s2_valid_r, s2_sign_r, s2_guard_r, s2_ovf_r, s2_nan_r;
   logic [MAG_W-1:0] s2_mag_r;

   logic             s3_valid_r, s3_sign_r, s3_ovf_r, s3_nan_r;
   logic [MAG_W-1:0] s3_mag_r;

   logic             sat_s;
   logic [OUT_W-1:0] data_s;

   // Stage 1: unpack fields and classify the operand.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_sign_r  <= 1'b0;
         s1_exp_r   <= 8'd0;
         s1_mant_r  <= 24'd0;
         s1_zero_r  <= 1'b0;
         s1_inf_r   <= 1'b0;
         s1_nan_r   <= 1'b0;
      end else begin
         s1_valid_r <= in_valid;
         s1_sign_r  <= in_data[31];
         s1_exp_r   <= in_data[30:23];
         s1_mant_r  <= {1'b1, in_data[22:0]};
         s1_zero_r  <= (in_data[30:23] == 8'd0);
         s1_inf_r   <= (in_data[30:23] == 8'hFF) && (in_data[22:0] == 23'd0);
         s1_nan_r   <= (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
      end
   end

   assign shift_s = $signed({3'b000, s1_exp_r}) - BIAS_S;
   assign neg_s   = -shift_s;
   assign lmag_s  = {{(MAG_W-24){1'b0}}, s1_mant_r} << shift_s[7:0];
   assign rv_s    = {s1_mant_r, 1'b0} >> neg_s[7:0];

   // Stage 2 alignment: the hidden bit lands at 23+shift, so overflow is a pure shift compare.
   always_comb begin
      mag_s   = '0;
      guard_s = 1'b0;
      ovf_s   = 1'b0;
      if (s1_zero_r || s1_nan_r) begin
         mag_s = '0;
      end else if (s1_inf_r) begin
         ovf_s = 1'b1;
      end else if (!shift_s[10]) begin
         if (shift_s >= OVF_SHIFT) begin
            ovf_s = 1'b1;
         end else begin
            mag_s = lmag_s;
         end
      end else if (neg_s >= 11'sd25) begin
         mag_s = '0;
      end else begin
         mag_s   = {{(MAG_W-24){1'b0}}, rv_s[24:1]};
         guard_s = rv_s[0];
      end
   end

   // Stage 2 registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_r <= 1'b0;
         s2_sign_r  <= 1'b0;
         s2_mag_r   <= '0;
         s2_guard_r <= 1'b0;
         s2_ovf_r   <= 1'b0;
         s2_nan_r   <= 1'b0;
      end else begin
         s2_valid_r <= s1_valid_r;
         s2_sign_r  <= s1_sign_r;
         s2_mag_r   <= mag_s;
         s2_guard_r <= guard_s;
         s2_ovf_r   <= ovf_s;
         s2_nan_r   <= s1_nan_r;
      end
   end

   // Stage 3: round the magnitude; cannot wrap since an unflagged magnitude is below 2^OUT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_valid_r <= 1'b0;
         s3_sign_r  <= 1'b0;
         s3_mag_r   <= '0;
         s3_ovf_r   <= 1'b0;
         s3_nan_r   <= 1'b0;
      end else begin
         s3_valid_r <= s2_valid_r;
         s3_sign_r  <= s2_sign_r;
         s3_mag_r   <= s2_mag_r + {{(MAG_W-1){1'b0}}, s2_guard_r};
         s3_ovf_r   <= s2_ovf_r;
         s3_nan_r   <= s2_nan_r;
      end
   end

   // Saturate per sign, then negate; a negative magnitude of exactly 2^(OUT_W-1) is representable.
   always_comb begin
      sat_s  = 1'b0;
      data_s = '0;
      if (s3_nan_r) begin
         sat_s  = 1'b0;
         data_s = '0;
      end else if (s3_ovf_r || (s3_sign_r ? (s3_mag_r > NEG_MAG) : (s3_mag_r > POS_MAX))) begin
         sat_s  = 1'b1;
         data_s = s3_sign_r ? SAT_NEG : SAT_POS;
      end else if (s3_sign_r) begin
         data_s = -s3_mag_r[OUT_W-1:0];
      end else begin
         data_s = s3_mag_r[OUT_W-1:0];
      end
   end

   // Output registers hold their last result while no operand exits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         ovf       <= 1'b0;
         nan       <= 1'b0;
      end else begin
         out_valid <= s3_valid_r;
         if (s3_valid_r) begin
            out_data <= data_s;
            ovf      <= sat_s;
            nan      <= s3_nan_r;
         end else begin
            out_data <= out_data;
            ovf      <= ovf;
            nan      <= nan;
         end
      end
   end

endmodule

// File: tb/tb_float_to_fix.sv
// Directed-vector bench for float_to_fix with a real-arithmetic reference model.
module tb_float_to_fix;

   localparam int OUT_W = 24;
   localparam int FRAC  = 8;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic [31:0]      in_data;
   logic             out_valid;
   logic [OUT_W-1:0] out_data;
   logic             ovf;
   logic             nan;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [OUT_W+1:0] expv;
      int               due;
      logic [31:0]      op;
   } ent_t;
   ent_t q[$];

   logic [OUT_W+1:0] last_r = '0;

   float_to_fix #(.OUT_W(OUT_W), .FRAC(FRAC)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_data (out_data),
      .ovf      (ovf),
      .nan      (nan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {nan, ovf, data} from the real value of the operand scaled by 2^FRAC.
   function automatic logic [OUT_W+1:0] model(input logic [31:0] f);
      int  e = int'(f[30:23]);
      int  m = int'({1'b1, f[22:0]});
      real v, r;
      longint qv;
      logic [OUT_W-1:0] d;
      if (e == 255 && f[22:0] != 23'd0) return {1'b1, 1'b0, {OUT_W{1'b0}}};
      if (e == 0) return '0;
      if (e == 255) return {1'b0, 1'b1, f[31] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}}};
      v = real'(m) * (2.0 ** real'(e - 150 + FRAC));
      r = $floor(v + 0.5);
      if (f[31]) r = -r;
      if (r > (2.0 ** (OUT_W - 1)) - 1.0) return {1'b0, 1'b1, 1'b0, {(OUT_W-1){1'b1}}};
      if (r < -(2.0 ** (OUT_W - 1)))      return {1'b0, 1'b1, 1'b1, {(OUT_W-1){1'b0}}};
      qv = longint'(r);
      d  = qv[OUT_W-1:0];
      return {1'b0, 1'b0, d};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Scoreboard entry per accepted operand; due on the third edge after acceptance.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst_n === 1'b1 && in_valid === 1'b1)
         q.push_back('{expv: model(in_data), due: cyc + 3, op: in_data});
   end

   always @(negedge rst_n) begin
      q.delete();
      last_r = '0;
   end

   // Output checker: valid exactly when due, otherwise outputs hold.
   always @(negedge clk) begin
      if (q.size() > 0 && q[0].due <= cyc) begin
         check("out_valid_due", {31'd0, out_valid}, 32'd1);
         check("out_data", {8'd0, out_data}, {8'd0, q[0].expv[OUT_W-1:0]});
         check("ovf", {31'd0, ovf}, {31'd0, q[0].expv[OUT_W]});
         check("nan", {31'd0, nan}, {31'd0, q[0].expv[OUT_W+1]});
         last_r = q[0].expv;
         void'(q.pop_front());
      end else begin
         check("out_valid_idle", {31'd0, out_valid}, 32'd0);
         check("hold_data", {8'd0, out_data}, {8'd0, last_r[OUT_W-1:0]});
         check("hold_flags", {30'd0, nan, ovf}, {30'd0, last_r[OUT_W+1:OUT_W]});
      end
   end

   task automatic send(input logic [31:0] d);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = 32'h0;
      end
   endtask

   logic [31:0] vec [20] = '{
      32'h3F800000, 32'hC0200000, 32'h3B000000, 32'hBB000000, 32'h3A800000,
      32'h00000001, 32'h47800000, 32'hC7000000, 32'h46FFFFFF, 32'hFF800000,
      32'h7FC00000, 32'h3F800000, 32'h3B400000, 32'h3AC00000, 32'h80000000,
      32'h7F800000, 32'hC7000001, 32'hFF800001, 32'h3F000000, 32'h4B000000
   };

   logic [31:0]      pin_op  [10] = '{
      32'h3F800000, 32'hC0200000, 32'h3B000000, 32'hBB000000, 32'h3A800000,
      32'h47800000, 32'hC7000000, 32'h46FFFFFF, 32'hFF800000, 32'h7FC00000
   };
   logic [OUT_W+1:0] pin_exp [10] = '{
      26'h0000100, 26'h0FFFD80, 26'h0000001, 26'h0FFFFFF, 26'h0000000,
      26'h17FFFFF, 26'h0800000, 26'h17FFFFF, 26'h1800000, 26'h2000000
   };

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {8'd0, out_data}, 32'd0);
      check("rst_flags", {30'd0, nan, ovf}, 32'd0);

      for (int i = 0; i < 10; i++)
         check("model_pin", {6'd0, model(pin_op[i])}, {6'd0, pin_exp[i]});

      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) send(vec[i]);
      idle(1);
      send(32'h3F800000);
      idle(1);
      send(32'hC0200000);
      idle(6);

      send(32'h40400000);
      send(32'hC0400000);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_data", {8'd0, out_data}, 32'd0);
      check("midrst_flags", {30'd0, nan, ovf}, 32'd0);
      check("midrst_stage", {29'd0, dut.s1_valid_r, dut.s2_valid_r, dut.s3_valid_r}, 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(6);
      send(32'h3F800000);
      idle(6);
      check("queue_drained", q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
